fft_regs_load_ctrl: RTL and testbench
=====================================

Name: fft_regs_load_ctrl

Overview:
- Sequences the 4-entry complex sample register bank that feeds the radix-4 butterfly in the 32-point FFT.
- Accepts a valid/ready sample stream and steers each sample into bank slot 0..3 with a registered one-hot enable.
- Fires the butterfly once the bank holds 4 samples, then waits for its completion before reloading.
- Counts groups per frame and flags frame completion.

Parameters:
- bits, 16, width of each real/imag half; samples are 2*bits wide.
- N, 32, points per frame; must be a multiple of 4.
- GW, 3, group counter width, equal to clog2(N/4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- flush  input  1  synchronous abort; returns to LOAD with counters cleared.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  2*bits  complex sample, {real, imag}.
- reg_en  output  4  one-hot write enable to the register bank.
- reg_data  output  2*bits  data to the bank, registered copy of in_data.
- bf_start  output  1  one-cycle pulse: bank full, butterfly may start.
- bf_done  input  1  butterfly finished with the bank (pulse or level).
- grp_idx  output  GW  index of the group currently in the bank.
- frame_done  output  1  one-cycle pulse after the last group's bf_done.
- busy  output  1  high in every state except LOAD with slot=0 and grp_cnt=0.

Behaviour:
- Reset clears state to LOAD, slot to 0, grp_cnt to 0, reg_en to 0, reg_data to 0, bf_start to 0 and frame_done to 0.
- in_ready is a combinational decode of the state: it is 1 only in LOAD. It is therefore 1 during and right after reset; upstream must hold in_valid low during reset.
- grp_idx equals grp_cnt.
- States: LOAD, FIRE, START, WAIT.
- LOAD:
  - A handshake is in_valid and in_ready at a clock edge.
  - On a handshake, the edge registers reg_data <= in_data and reg_en <= 1<<slot, then increments slot.
  - reg_en is therefore a one-cycle pulse in the cycle after the handshake, and the bank captures on that next edge.
  - With no handshake, reg_en returns to 0.
  - A handshake with slot=3 moves to FIRE and wraps slot to 0.
- FIRE: lasts 1 cycle. reg_en=4'b1000 is visible here, so slot 3 is written at the end of FIRE. Next state is START.
- START: lasts 1 cycle with bf_start=1 and reg_en=0. Next state is WAIT.
- WAIT:
  - in_ready=0.
  - When bf_done=1 is sampled: if grp_cnt==N/4-1, set grp_cnt to 0 and pulse frame_done for 1 cycle; otherwise increment grp_cnt. Then move to LOAD.
  - Back-to-back streaming gives in_ready low for 3 cycles minimum (FIRE, START, and one WAIT cycle) per group.
- bf_done in LOAD, FIRE or START is ignored and not remembered.
- bf_done held high gives one group step per WAIT visit only.
- flush has priority over every transition:
  - At the edge it returns to LOAD and clears slot, grp_cnt, reg_en and bf_start.
  - An in_valid in the same cycle is not accepted. in_ready still reads 1 if the state is LOAD; upstream must treat that sample as dropped.
  - A flush in WAIT abandons the group with no frame_done.
- reset mid-operation (asynchronous) behaves exactly as power-on reset. A bf_start or reg_en pulse in flight is cancelled immediately.
- reg_en never has more than one bit set. At most one bank write occurs per cycle.
- Data is passed through unmodified: no arithmetic and no width change.

Test Plan:
- Reset, then 4 consecutive valid samples 0x00010002, 0x00030004, 0x00050006, 0x00070008:
  - reg_en goes 0001, 0010, 0100, 1000 on cycles 1-4 after the first handshake, with matching reg_data.
  - bf_start pulses on the cycle after the 1000 cycle.
  - in_ready is 0 from FIRE onward.
- Full frame, 32 samples with bf_done returned 2 cycles after each bf_start:
  - grp_idx steps 0..7.
  - frame_done pulses exactly once, after the 8th bf_done.
  - grp_idx returns to 0.
- in_valid toggling 1,0,0,1,1,0,1:
  - exactly 4 reg_en pulses, one per handshake.
  - No write on idle cycles; slot order is preserved.
- bf_done pulsed in LOAD and in START, then held high in WAIT for 5 cycles:
  - The early pulses are ignored.
  - grp_cnt advances by exactly 1.
- flush after 2 samples:
  - reg_en=0 on the next cycle, slot=0, grp_idx=0.
  - The next 4 samples land in slots 0..3.
- reset asserted asynchronously during WAIT with grp_idx=5:
  - All outputs go to reset values immediately and in_ready=1.
  - A subsequent bf_done has no effect.

Source files
------------

// File: rtl/fft_regs_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// fft_regs_load_ctrl_if
// Bundles the sample stream, register-bank write port and butterfly handshake
// used by fft_regs_load_ctrl.
//   master : the environment side (upstream source, butterfly, flush control)
//   slave  : the load controller itself
// Signals:
//   flush      master->slave  synchronous abort
//   in_valid   master->slave  upstream sample valid
//   in_data    master->slave  complex sample {real, imag}, 2*bits wide
//   bf_done    master->slave  butterfly finished with the bank
//   in_ready   slave->master  controller can accept a sample
//   reg_en     slave->master  one-hot bank slot write enable
//   reg_data   slave->master  registered sample for the bank
//   bf_start   slave->master  one-cycle butterfly start pulse
//   grp_idx    slave->master  group currently held in the bank
//   frame_done slave->master  one-cycle pulse after the last group completes
//   busy       slave->master  controller is not idle
// -----------------------------------------------------------------------------
interface fft_regs_load_ctrl_if #(
  parameter int bits = 16,
  parameter int GW   = 3
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [2*bits-1:0]   in_data;
  logic [3:0]          reg_en;
  logic [2*bits-1:0]   reg_data;
  logic                bf_start;
  logic                bf_done;
  logic [GW-1:0]       grp_idx;
  logic                frame_done;
  logic                busy;

  modport master (
    output flush, in_valid, in_data, bf_done,
    input  in_ready, reg_en, reg_data, bf_start, grp_idx, frame_done, busy
  );

  modport slave (
    input  flush, in_valid, in_data, bf_done,
    output in_ready, reg_en, reg_data, bf_start, grp_idx, frame_done, busy
  );
endinterface

// File: rtl/fft_regs_load_ctrl.sv
// -----------------------------------------------------------------------------
// fft_regs_load_ctrl
// Sequences the 4-entry complex sample register bank in front of the radix-4
// butterfly of an N-point FFT. Samples arriving on a valid/ready stream are
// steered into bank slots 0..3 through a registered one-hot write enable; when
// the bank is full the butterfly is started and the controller waits for it to
// release the bank before loading the next group. Groups are counted per frame
// and the end of a frame is flagged with a one-cycle pulse.
// Parameters:
//   bits : width of each real/imag half (samples are 2*bits wide)
//   N    : points per frame, a multiple of 4
//   GW   : group counter width, clog2(N/4); must match the interface GW
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of fft_regs_load_ctrl_if (stream, bank, butterfly)
// -----------------------------------------------------------------------------
module fft_regs_load_ctrl #(
  parameter int bits = 16,
  parameter int N    = 32,
  parameter int GW   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_regs_load_ctrl_if.slave  bus
);

  localparam logic [GW-1:0] LAST_GRP = GW'(N / 4 - 1);
  localparam logic [GW-1:0] GRP_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] GRP_ONE  = {{(GW-1){1'b0}}, 1'b1};

  // LOAD  : accepting samples into slots 0..3
  // FIRE  : slot 3 write enable is on the bank port
  // START : butterfly start pulse
  // WAIT  : butterfly owns the bank until bf_done
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FIRE  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [1:0]          slot_r, slot_s;
  logic [GW-1:0]       grp_cnt_r, grp_cnt_s;
  logic [3:0]          reg_en_r, reg_en_s;
  logic [2*bits-1:0]   reg_data_r, reg_data_s;
  logic                bf_start_r, bf_start_s;
  logic                frame_done_r, frame_done_s;
  logic                in_ready_s;
  logic                accept_s;

  // Slot number to bank write enable; never more than one bit set.
  function automatic logic [3:0] slot_onehot(input logic [1:0] slot);
    logic [3:0] en;
    case (slot)
      2'd0:    en = 4'b0001;
      2'd1:    en = 4'b0010;
      2'd2:    en = 4'b0100;
      2'd3:    en = 4'b1000;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  // Ready is a pure state decode, so it stays high in a flushed LOAD cycle
  // even though that sample is discarded.
  assign in_ready_s = (state_r == LOAD);
  assign accept_s   = bus.in_valid & in_ready_s & ~bus.flush;

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_s      = state_r;
    slot_s       = slot_r;
    grp_cnt_s    = grp_cnt_r;
    reg_en_s     = 4'b0000;
    reg_data_s   = reg_data_r;
    bf_start_s   = 1'b0;
    frame_done_s = 1'b0;

    if (bus.flush) begin
      // Abort wins over everything: drop the partial group, no frame_done.
      state_s   = LOAD;
      slot_s    = 2'd0;
      grp_cnt_s = GRP_ZERO;
    end else begin
      case (state_r)
        LOAD: begin
          if (accept_s) begin
            reg_en_s   = slot_onehot(slot_r);
            reg_data_s = bus.in_data;
            slot_s     = slot_r + 2'd1;  // wraps 3 -> 0
            if (slot_r == 2'd3) begin
              state_s = FIRE;
            end else begin
              state_s = LOAD;
            end
          end else begin
            state_s = LOAD;
          end
        end
        FIRE: begin
          // Slot 3 is written at the end of this cycle; start follows next.
          state_s    = START;
          bf_start_s = 1'b1;
        end
        START: begin
          state_s = WAIT;
        end
        WAIT: begin
          // A bf_done held high only counts once: we leave WAIT immediately.
          if (bus.bf_done) begin
            state_s = LOAD;
            if (grp_cnt_r == LAST_GRP) begin
              grp_cnt_s    = GRP_ZERO;
              frame_done_s = 1'b1;
            end else begin
              grp_cnt_s    = grp_cnt_r + GRP_ONE;
            end
          end else begin
            state_s = WAIT;
          end
        end
        default: begin
          state_s   = LOAD;
          slot_s    = 2'd0;
          grp_cnt_s = GRP_ZERO;
        end
      endcase
    end
  end

  // State, counters and registered outputs; reset cancels any pulse in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= LOAD;
      slot_r       <= 2'd0;
      grp_cnt_r    <= GRP_ZERO;
      reg_en_r     <= 4'b0000;
      reg_data_r   <= {(2*bits){1'b0}};
      bf_start_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      slot_r       <= slot_s;
      grp_cnt_r    <= grp_cnt_s;
      reg_en_r     <= reg_en_s;
      reg_data_r   <= reg_data_s;
      bf_start_r   <= bf_start_s;
      frame_done_r <= frame_done_s;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.reg_en     = reg_en_r;
  assign bus.reg_data   = reg_data_r;
  assign bus.bf_start   = bf_start_r;
  assign bus.grp_idx    = grp_cnt_r;
  assign bus.frame_done = frame_done_r;
  // Idle means nothing loaded and no group of the frame consumed yet.
  assign bus.busy       = ~((state_r == LOAD) && (slot_r == 2'd0) && (grp_cnt_r == GRP_ZERO));

endmodule

// File: tb/tb_fft_regs_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_regs_load_ctrl
// Directed self-checking bench for fft_regs_load_ctrl: a vector table for the
// basic load/fire/wait flow, then hand-written sequences for a full frame,
// flush and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_fft_regs_load_ctrl;

  logic clk;
  logic reset;

  fft_regs_load_ctrl_if #(.bits(16), .GW(3)) bus ();

  fft_regs_load_ctrl #(.bits(16), .N(32), .GW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  int fd_seen;

  // Count frame_done pulses seen on the falling edge.
  initial fd_seen = 0;
  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fd_seen = fd_seen + 1;
  end

  // Packed observation: {in_ready, reg_en, reg_data, bf_start, grp_idx, frame_done, busy}
  function automatic logic [42:0] outs();
    return {bus.in_ready, bus.reg_en, bus.reg_data, bus.bf_start,
            bus.grp_idx, bus.frame_done, bus.busy};
  endfunction

  function automatic logic [42:0] pack(input logic rdy, input logic [3:0] en,
                                       input logic [31:0] rd, input logic st,
                                       input logic [2:0] g, input logic fd,
                                       input logic bsy);
    return {rdy, en, rd, st, g, fd, bsy};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    bus.bf_done  = 1'b0;
    bus.flush    = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_state", 64'(outs()), 64'(pack(1'b1, 4'b0000, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0)));
  endtask

  // Stream four samples back-to-back and check each lands in the next slot.
  task automatic load_group(input logic [31:0] base);
    for (int s = 0; s < 4; s++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + 32'(s);
      tick();
      chk($sformatf("slot%0d_en", s), 64'(bus.reg_en), 64'(4'b0001 << s));
      chk($sformatf("slot%0d_data", s), 64'(bus.reg_data), 64'(base + 32'(s)));
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (bus.bf_start !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("bf_start_seen", 64'(bus.bf_start), 64'(1'b1));
  endtask

  // Return bf_done two cycles after the bf_start cycle.
  task automatic complete();
    tick();
    tick();
    bus.bf_done = 1'b1;
    tick();
    bus.bf_done = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        done;
    logic [42:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic v, input logic [31:0] d, input logic done,
                     input logic [42:0] exp);
    vec_t r;
    r.v = v; r.d = d; r.done = done; r.exp = exp;
    vq.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a1, a2, a3, a4;
    int fd_base;
    tests = 0;
    fails = 0;
    a1 = 32'hA1A1_0001; a2 = 32'hA2A2_0002; a3 = 32'hA3A3_0003; a4 = 32'hA4A4_0004;

    // Basic group: four samples, fire, start, wait, done.
    add(1'b1, 32'h00010002, 1'b0, pack(1'b1, 4'b0001, 32'h00010002, 1'b0, 3'd0, 1'b0, 1'b1));
    add(1'b1, 32'h00030004, 1'b0, pack(1'b1, 4'b0010, 32'h00030004, 1'b0, 3'd0, 1'b0, 1'b1));
    add(1'b1, 32'h00050006, 1'b0, pack(1'b1, 4'b0100, 32'h00050006, 1'b0, 3'd0, 1'b0, 1'b1));
    add(1'b1, 32'h00070008, 1'b0, pack(1'b0, 4'b1000, 32'h00070008, 1'b0, 3'd0, 1'b0, 1'b1));
    add(1'b0, 32'h0,        1'b0, pack(1'b0, 4'b0000, 32'h00070008, 1'b1, 3'd0, 1'b0, 1'b1));
    add(1'b0, 32'h0,        1'b0, pack(1'b0, 4'b0000, 32'h00070008, 1'b0, 3'd0, 1'b0, 1'b1));
    add(1'b0, 32'h0,        1'b1, pack(1'b1, 4'b0000, 32'h00070008, 1'b0, 3'd1, 1'b0, 1'b1));
    // bf_done in LOAD is ignored.
    add(1'b0, 32'h0,        1'b1, pack(1'b1, 4'b0000, 32'h00070008, 1'b0, 3'd1, 1'b0, 1'b1));
    // in_valid toggling 1,0,0,1,1,0,1.
    add(1'b1, a1,    1'b0, pack(1'b1, 4'b0001, a1, 1'b0, 3'd1, 1'b0, 1'b1));
    add(1'b0, 32'h0, 1'b0, pack(1'b1, 4'b0000, a1, 1'b0, 3'd1, 1'b0, 1'b1));
    add(1'b0, 32'h0, 1'b0, pack(1'b1, 4'b0000, a1, 1'b0, 3'd1, 1'b0, 1'b1));
    add(1'b1, a2,    1'b0, pack(1'b1, 4'b0010, a2, 1'b0, 3'd1, 1'b0, 1'b1));
    add(1'b1, a3,    1'b0, pack(1'b1, 4'b0100, a3, 1'b0, 3'd1, 1'b0, 1'b1));
    add(1'b0, 32'h0, 1'b0, pack(1'b1, 4'b0000, a3, 1'b0, 3'd1, 1'b0, 1'b1));
    add(1'b1, a4,    1'b0, pack(1'b0, 4'b1000, a4, 1'b0, 3'd1, 1'b0, 1'b1));
    // In FIRE: valid not accepted, bf_done ignored.
    add(1'b1, 32'hDEAD0000, 1'b1, pack(1'b0, 4'b0000, a4, 1'b1, 3'd1, 1'b0, 1'b1));
    // In START: bf_done ignored.
    add(1'b0, 32'h0, 1'b1, pack(1'b0, 4'b0000, a4, 1'b0, 3'd1, 1'b0, 1'b1));
    // Held high through WAIT and four LOAD cycles: exactly one step.
    add(1'b0, 32'h0, 1'b1, pack(1'b1, 4'b0000, a4, 1'b0, 3'd2, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++)
      add(1'b0, 32'h0, 1'b1, pack(1'b1, 4'b0000, a4, 1'b0, 3'd2, 1'b0, 1'b1));
    add(1'b0, 32'h0, 1'b0, pack(1'b1, 4'b0000, a4, 1'b0, 3'd2, 1'b0, 1'b1));

    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      bus.in_valid = vq[i].v;
      bus.in_data  = vq[i].d;
      bus.bf_done  = vq[i].done;
      tick();
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(vq[i].exp));
    end
    bus.in_valid = 1'b0;
    bus.bf_done  = 1'b0;

    // Full frame of eight groups.
    do_reset();
    fd_base = fd_seen;
    for (int g = 0; g < 8; g++) begin
      chk($sformatf("frame_grp%0d", g), 64'(bus.grp_idx), 64'(g));
      load_group(32'(g * 16));
      wait_start();
      complete();
      if (g == 7) chk("frame_done_pulse", 64'(bus.frame_done), 64'(1'b1));
      else        chk($sformatf("no_frame_done%0d", g), 64'(bus.frame_done), 64'(1'b0));
    end
    tick();
    chk("frame_done_cleared", 64'(bus.frame_done), 64'(1'b0));
    chk("frame_done_count", 64'(fd_seen - fd_base), 64'(1));
    chk("frame_grp_wrap", 64'(bus.grp_idx), 64'(0));
    chk("frame_idle", 64'(bus.busy), 64'(1'b0));

    // Flush after two samples of group 1.
    load_group(32'h1000_0000);
    wait_start();
    complete();
    chk("pre_flush_grp", 64'(bus.grp_idx), 64'(1));
    bus.in_valid = 1'b1; bus.in_data = 32'h0000_1111; tick();
    bus.in_data  = 32'h0000_2222; tick();
    chk("pre_flush_en", 64'(bus.reg_en), 64'(4'b0010));
    bus.in_data = 32'hDEAD_BEEF;
    bus.flush   = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_state", 64'(outs()), 64'(pack(1'b1, 4'b0000, 32'h0000_2222, 1'b0, 3'd0, 1'b0, 1'b0)));
    load_group(32'h2000_0000);
    wait_start();
    complete();

    // Asynchronous reset while waiting on group 5.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      load_group(32'(32'h3000_0000 + g * 16));
      wait_start();
      complete();
    end
    load_group(32'h4000_0000);
    wait_start();
    tick();
    chk("wait_before_reset", 64'({bus.in_ready, bus.grp_idx}), 64'({1'b0, 3'd5}));
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset", 64'(outs()), 64'(pack(1'b1, 4'b0000, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0)));
    #2;
    reset = 1'b0;
    bus.bf_done = 1'b1;
    tick();
    bus.bf_done = 1'b0;
    chk("post_reset_done", 64'(outs()), 64'(pack(1'b1, 4'b0000, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
